// File: rtl/interval_timer_pkg.sv
// Shared types and helpers for the interval timer sequencer.
//   seq_state_e : sequencer states IDLE/LOAD/RUN/DONE
//   all_ones    : w-bit all-ones constant (returned in 32 bits, truncate at use)
//   reload_val  : 2^w - p, the counter preload that gives p counted cycles to terminal count
package interval_timer_pkg;

  localparam int unsigned SEQ_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // w-bit all-ones; 1<<32 wraps to 0 in 32 bits, so w=32 still yields all-ones
  function automatic logic [31:0] all_ones(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // 2^w - p modulo 2^w once the caller truncates to w bits
  function automatic logic [31:0] reload_val(input int unsigned w, input logic [31:0] p);
    return (32'd1 << w) - p;
  endfunction

endpackage

// File: rtl/par_load_counter.sv
// W-bit binary up-counter with parallel load.
//   clk, rstn : clock, asynchronous active-low reset
//   load      : load d on the next edge (priority over count)
//   count     : increment on the next edge, wraps all-ones -> 0
//   d         : load value
//   q         : live counter value (registered)
//   co_c      : carry out, counter at all-ones while count is asserted
module par_load_counter
  import interval_timer_pkg::*;
#(
  parameter int unsigned W = SEQ_W_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         co_c
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  // Next value: load beats count
  always_comb begin
    val_d = val_q;
    if (load) begin
      val_d = d;
    end else if (count) begin
      val_d = val_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q    = val_q;
  assign co_c = (val_q == W'(all_ones(W))) & count;

endmodule

// File: rtl/interval_timer_seq.sv
// Programmable interval timer sequencer driving a par_load_counter.
// Start preloads the counter with 2^W-P, then counts to terminal count; each
// terminal count produces a tick and either ends the run (one-shot) or reloads
// in the same cycle (auto-reload).
// Optional build macro: SEQ_PRESCALE_EN adds a modulo-PRESCALE count-enable divider.
//   clk, rstn : clock, asynchronous active-low reset
//   start     : launch request (IDLE only); auto_rld/period sampled with it
//   stop      : synchronous abort from any state
//   ack       : clears pend
//   busy      : sequencer not idle
//   tick      : one-cycle pulse per expired interval
//   done      : one-cycle pulse at the end of a one-shot run
//   pend      : sticky tick-pending flag
//   overrun   : sticky, tick arrived while pend was still set
//   err       : one-cycle pulse, start with period==0 rejected
//   count_q   : live counter value
module interval_timer_seq
  import interval_timer_pkg::*;
#(
  parameter int unsigned W        = SEQ_W_DEF,
  parameter int unsigned PRESCALE = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         stop,
  input  logic         auto_rld,
  input  logic [W-1:0] period,
  input  logic         ack,
  output logic         busy,
  output logic         tick,
  output logic         done,
  output logic         pend,
  output logic         overrun,
  output logic         err,
  output logic [W-1:0] count_q
);

  if (PRESCALE < 1) begin : g_prescale_chk
    $error("interval_timer_seq: PRESCALE must be >= 1");
  end

  seq_state_e   state_q, state_d;
  logic [W-1:0] period_q, period_d;
  logic         rld_q, rld_d;
  logic         busy_q, busy_d;
  logic         tick_q, tick_d;
  logic         done_q, done_d;
  logic         pend_q, pend_d;
  logic         overrun_q, overrun_d;
  logic         err_q, err_d;

  logic         run_c;
  logic         cnt_load_c;
  logic         cnt_count_c;
  logic [W-1:0] cnt_data_c;
  logic         term_c;

  // RUN and not being aborted this cycle
  assign run_c = (state_q == ST_RUN) & ~stop;

`ifdef SEQ_PRESCALE_EN
  localparam int unsigned    PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

  logic [PSW-1:0] presc_q, presc_d;

  // Divider advances only while running; any other state (or stop) clears it
  always_comb begin
    presc_d = '0;
    if (run_c) begin
      presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PSW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign cnt_count_c = run_c & (presc_q == PS_LAST);
`else
  assign cnt_count_c = run_c;
`endif

  // Counter carry already includes cnt_count_c, so it is the terminal count
  par_load_counter #(
    .W (W)
  ) u_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .load  (cnt_load_c),
    .count (cnt_count_c),
    .d     (cnt_data_c),
    .q     (count_q),
    .co_c  (term_c)
  );

  // Next state, counter control and flag updates
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    rld_d      = rld_q;
    err_d      = 1'b0;
    cnt_load_c = 1'b0;
    cnt_data_c = W'(reload_val(W, 32'(period_q)));
    // tick_q is the visible tick, so ack in the tick cycle cannot clear pend
    pend_d     = tick_q | (pend_q & ~ack);
    overrun_d  = overrun_q | (tick_q & pend_q);

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          if (period != '0) begin
            period_d  = period;
            rld_d     = auto_rld;
            overrun_d = 1'b0;
            state_d   = ST_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        cnt_load_c = 1'b1;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        if (term_c) begin
          // Reload in the terminal cycle so the next interval is exactly P counts
          if (rld_q) begin
            cnt_load_c = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort: counter frozen, back to IDLE
    if (stop) begin
      state_d    = ST_IDLE;
      cnt_load_c = 1'b0;
    end

    tick_d = term_c;
    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      period_q  <= '0;
      rld_q     <= 1'b0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      pend_q    <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      rld_q     <= rld_d;
      busy_q    <= busy_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

  assign busy    = busy_q;
  assign tick    = tick_q;
  assign done    = done_q;
  assign pend    = pend_q;
  assign overrun = overrun_q;
  assign err     = err_q;

endmodule

// File: tb/tb_interval_timer_seq.sv
// Bench for interval_timer_seq: directed stimulus; expected tick events are
// queued at launch and popped by an independent monitor when tick appears.
module tb_interval_timer_seq;

  localparam int unsigned W = 4;
`ifdef SEQ_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic         clk;
  logic         rstn;
  logic         start;
  logic         stop;
  logic         auto_rld;
  logic [W-1:0] period;
  logic         ack;
  logic         busy;
  logic         tick;
  logic         done;
  logic         pend;
  logic         overrun;
  logic         err;
  logic [W-1:0] count_q;

  interval_timer_seq #(
    .W        (W),
    .PRESCALE (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .stop     (stop),
    .auto_rld (auto_rld),
    .period   (period),
    .ack      (ack),
    .busy     (busy),
    .tick     (tick),
    .done     (done),
    .pend     (pend),
    .overrun  (overrun),
    .err      (err),
    .count_q  (count_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   at;
    logic done;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every tick must match the head of the expected-event queue
  always @(negedge clk) begin
    if (rstn) begin
      if (tick) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tick: got tick at cycle %0d expected none", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("tick_cycle", 32'(cyc), 32'(e.at));
          chk("tick_done", 32'(done), 32'(e.done));
        end
      end else if (done) begin
        checks++;
        errors++;
        $display("FAIL done_without_tick: got done=1 tick=0 expected tick with done (cycle %0d)", cyc);
      end
    end
  end

  // Call at a negedge; returns the accepting edge index and queues expected ticks
  task automatic launch(input logic [W-1:0] p, input logic rld, input int nticks, output int e);
    start    = 1'b1;
    period   = p;
    auto_rld = rld;
    @(negedge clk);
    start = 1'b0;
    e     = cyc;
    for (int n = 0; n < nticks; n++) begin
      exp_t x;
      x.at   = e + int'(p) * PS + 1 + n * int'(p) * PS;
      x.done = !rld && (n == 0);
      sbq.push_back(x);
    end
  endtask

  function automatic logic [31:0] outs();
    return {18'd0, busy, tick, done, pend, overrun, err, 4'(count_q)};
  endfunction

  initial begin
    int e;
    rstn = 1'b0; start = 1'b0; stop = 1'b0; auto_rld = 1'b0; period = '0; ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

`ifndef SEQ_PRESCALE_EN
    // One-shot P=3: preload 13, count 13,14,15,0; tick+done with 0, busy drops after
    launch(4'd3, 1'b0, 1, e);
    chk("p3_busy_load", 32'(busy), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      logic [3:0] seq3 [5];
      seq3 = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd0};
      @(negedge clk);
      chk("p3_count", 32'(count_q), 32'(seq3[i-1]));
      if (i == 4) chk("p3_busy_done", 32'(busy), 32'd1);
      if (i == 5) begin
        chk("p3_busy_idle", 32'(busy), 32'd0);
        chk("p3_pend", 32'(pend), 32'd1);
        ack = 1'b1;
      end
    end
    @(negedge clk);
    ack = 1'b0;
    chk("p3_pend_ack", 32'(pend), 32'd0);

    // Auto-reload P=5: 11..15 repeating, period change and restart ignored, flags, stop on term
    launch(4'd5, 1'b1, 3, e);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("rld_count", 32'(count_q), 32'(11 + ((i - 1) % 5)));
      if (i == 3) begin period = 4'd2; auto_rld = 1'b0; end
      if (i == 6) chk("rld_pend_lag", 32'(pend), 32'd0);
      if (i == 7) chk("rld_pend_set", 32'(pend), 32'd1);
      if (i == 8) begin start = 1'b1; period = 4'd1; end else start = 1'b0;
      if (i == 11) chk("rld_ovr_pre", 32'(overrun), 32'd0);
      if (i == 12) chk("rld_ovr_set", 32'(overrun), 32'd1);
      if (i == 16) ack = 1'b1;
      else if (i == 17) begin chk("pend_tick_wins", 32'(pend), 32'd1); ack = 1'b1; end
      else ack = 1'b0;
      if (i == 18) chk("pend_ack_clr", 32'(pend), 32'd0);
      if (i == 20) stop = 1'b1;
    end
    @(negedge clk);
    stop = 1'b0;
    chk("stop_idle", 32'(busy), 32'd0);
    chk("stop_count_hold", 32'(count_q), 32'd15);
    chk("stop_ovr_sticky", 32'(overrun), 32'd1);

    // One-shot P=1 (tick at k+3) clears overrun; one-shot P=15 (tick at k+17)
    launch(4'd1, 1'b0, 1, e);
    chk("start_clr_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    chk("p1_count", 32'(count_q), 32'd15);
    repeat (2) @(negedge clk);
    chk("p1_idle", 32'(busy), 32'd0);
    launch(4'd15, 1'b0, 1, e);
    @(negedge clk);
    chk("p15_count", 32'(count_q), 32'd1);
    repeat (15) @(negedge clk);
    chk("p15_count_end", 32'(count_q), 32'd0);
    @(negedge clk);
    chk("p15_idle", 32'(busy), 32'd0);

    // Period 0 rejected
    start = 1'b1; period = 4'd0;
    @(negedge clk);
    start = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("err_one_cycle", 32'(err), 32'd0);
    chk("err_busy2", 32'(busy), 32'd0);

    // Async reset mid-run
    launch(4'd5, 1'b1, 0, e);
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("async_reset", outs(), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", 32'(busy), 32'd0);
`else
    // Prescale 4, P=2 auto-reload: tick every 8 cycles, restart while busy ignored
    launch(4'd2, 1'b1, 3, e);
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      if (i == 1) chk("ps_count_first", 32'(count_q), 32'd14);
      if (i == 4) chk("ps_count_hold", 32'(count_q), 32'd14);
      if (i == 5) chk("ps_count_step", 32'(count_q), 32'd15);
      if (i == 9) chk("ps_count_reload", 32'(count_q), 32'd14);
      if (i == 10) begin start = 1'b1; period = 4'd7; end else start = 1'b0;
      if (i == 20) chk("ps_busy", 32'(busy), 32'd1);
      if (i == 26) stop = 1'b1;
    end
    @(negedge clk);
    stop = 1'b0;
    chk("ps_stop_idle", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
`endif

    chk("all_ticks_seen", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
